// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner select for a shared 16:1 single-bit mux.
//   clk, rst        : clock, synchronous active-high reset
//   req[15:0]       : per-requester request lines
//   done            : current owner releases at the end of this cycle
//   sel[3:0]        : mux select, index of the current (or last) owner
//   grant[15:0]     : one-hot grant, zero when idle
//   busy            : a grant is active
//   timeout         : one-cycle pulse when the hold limit revokes a grant
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d, sel_q, sel_d, off, win;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] grant_q, grant_d, rot;
  logic        busy_q, busy_d, timeout_q, timeout_d, hold_hit, own_req, release_now;
  always_comb begin
    // Rotate so that bit 0 is the pointer position; the lowest set bit is the winner.
    rot = 16'({req, req} >> ptr_q);
    off = '0;
    for (int i = 15; i >= 0; i--) if (rot[i]) off = 4'(i);
    win = ptr_q + off;
    hold_hit = hold_q == 8'(MAX_HOLD - 1);
    own_req = req[sel_q];
    release_now = done || !own_req || hold_hit;
    state_d = state_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    sel_d = sel_q;
    grant_d = grant_q;
    busy_d = busy_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = OWNED;
        sel_d = win;
        grant_d = 16'(1) << win;
        busy_d = 1'b1;
        hold_d = '0;
      end
    end else begin
      hold_d = (hold_q == 8'hff) ? hold_q : hold_q + 8'd1;
      if (release_now) begin
        state_d = IDLE;
        grant_d = '0;
        busy_d = 1'b0;
        ptr_d = sel_q + 4'd1;
        // Done or a dropped request is a voluntary release and masks the timeout report.
        timeout_d = hold_hit && !done && own_req;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      hold_q <= '0;
      sel_q <= '0;
      grant_q <= '0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      sel_q <= sel_d;
      grant_q <= grant_d;
      busy_q <= busy_d;
      timeout_q <= timeout_d;
    end
  end
  assign sel = sel_q;
  assign grant = grant_q;
  assign busy = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed self-checking bench for mux16_rr_arbiter.
module tb_mux16_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy, timeout;
  logic [15:0] data = '0;
  logic        y;
  int checks = 0;
  int failures = 0;
  mux16_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
  );
  assign y = data[sel];
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    done = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req = 16'hffff;
    step();
    step();
    chk("reset_grant", grant, 16'h0000);
    chk("reset_sel", 16'(sel), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_timeout", 16'(timeout), 16'd0);
    rst = 1'b0;
    step();
    chk("reset_first_grant", grant, 16'h0001);
    chk("reset_first_busy", 16'(busy), 16'd1);
  endtask
  task automatic test_single;
    do_reset();
    req = 16'h0020;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("single_grant", grant, 16'h0020);
      chk("single_sel", 16'(sel), 16'd5);
      if (i == 3) done = 1'b1;
    end
    step();
    chk("single_release_grant", grant, 16'h0000);
    chk("single_release_busy", 16'(busy), 16'd0);
    chk("single_sel_hold", 16'(sel), 16'd5);
    chk("single_no_timeout", 16'(timeout), 16'd0);
    done = 1'b0;
    req = 16'h0041;
    step();
    chk("single_ptr_next", grant, 16'h0040);
    chk("single_ptr_sel", 16'(sel), 16'd6);
  endtask
  task automatic test_wrap;
    logic [15:0] exp_g [8];
    exp_g = '{16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000};
    do_reset();
    req = 16'h8001;
    done = 1'b1;
    data = 16'h2b8d;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wrap_grant", grant, exp_g[i]);
      if (i == 0) chk("wrap_mux_bit0", 16'(y), 16'd1);
      if (i == 7) begin
        chk("wrap_sel15", 16'(sel), 16'd15);
        chk("wrap_mux_bit15", 16'(y), 16'd0);
      end
    end
    done = 1'b0;
  endtask
  task automatic test_timeout;
    do_reset();
    req = 16'h0100;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("timeout_grant", grant, 16'h0100);
      chk("timeout_early", 16'(timeout), 16'd0);
    end
    step();
    chk("timeout_release", grant, 16'h0000);
    chk("timeout_pulse", 16'(timeout), 16'd1);
    step();
    chk("timeout_regrant", grant, 16'h0100);
    chk("timeout_one_cycle", 16'(timeout), 16'd0);
    req = '0;
    step();
    chk("timeout_drop_release", grant, 16'h0000);
    chk("timeout_drop_no_pulse", 16'(timeout), 16'd0);
  endtask
  task automatic test_simultaneous;
    do_reset();
    req = 16'h0004;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("simul_grant", grant, 16'h0004);
      if (i == 8) done = 1'b1;
    end
    step();
    chk("simul_release", grant, 16'h0000);
    chk("simul_no_timeout", 16'(timeout), 16'd0);
    done = 1'b0;
    req = '0;
  endtask
  task automatic test_reset_mid;
    do_reset();
    req = 16'h0200;
    step();
    chk("mid_sel9", 16'(sel), 16'd9);
    step();
    rst = 1'b1;
    step();
    chk("mid_grant", grant, 16'h0000);
    chk("mid_sel", 16'(sel), 16'd0);
    chk("mid_busy", 16'(busy), 16'd0);
    chk("mid_timeout", 16'(timeout), 16'd0);
    rst = 1'b0;
    req = 16'hffff;
    step();
    chk("mid_ptr0", grant, 16'h0001);
    chk("mid_after_timeout", 16'(timeout), 16'd0);
  endtask
  task automatic test_back_to_back;
    do_reset();
    req = 16'hffff;
    done = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      chk("fair_grant", grant, 16'(1) << (k % 16));
      step();
      chk("fair_gap", grant, 16'h0000);
    end
    done = 1'b0;
    req = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
